// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: instruction memory read port, decode handshake and redirect.
// master = instruction_fetch, slave = memory/decode/branch side.
interface instruction_fetch_if;
    logic [31:0] mem_read_address;
    logic [31:0] mem_instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output mem_read_address, out_valid, out_instruction, out_pc,
        input  mem_instruction, out_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  mem_read_address, out_valid, out_instruction, out_pc,
        output mem_instruction, out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: one synchronous-memory read per cycle, 2-entry output queue,
// redirect flushes queued and in-flight words.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input logic                   clk,
    input logic                   rst,
    instruction_fetch_if.master   bus
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic [31:0]      fetch_pc;
    logic             inflight;
    logic [31:0]      inflight_pc;
    logic [1:0]       count;
    entry_t [1:0]     q;
    entry_t           new_e;
    logic             out_valid;
    logic             pop;
    logic             push;
    logic [2:0]       occ;
    logic             issue;

    assign out_valid = (count != 2'd0) & ~bus.redirect_valid;
    assign pop       = out_valid & bus.out_ready;
    // A redirect discards the word returning this cycle.
    assign push      = inflight & ~bus.redirect_valid;
    assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign issue     = (occ < 3'd2) | bus.redirect_valid;
    assign new_e     = '{pc: inflight_pc, instr: bus.mem_instruction};

    assign bus.mem_read_address = bus.redirect_valid ? bus.redirect_pc : fetch_pc;
    assign bus.out_valid        = out_valid;
    assign bus.out_pc           = q[0].pc;
    assign bus.out_instruction  = q[0].instr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'd0;
            count       <= 2'd0;
            q           <= '0;
        end else begin
            if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= bus.mem_read_address;
                fetch_pc    <= bus.mem_read_address + 32'd1;
            end else begin
                inflight    <= 1'b0;
            end

            if (bus.redirect_valid) begin
                count <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b11: begin
                        if (count == 2'd2) begin
                            q[0] <= q[1];
                            q[1] <= new_e;
                        end else begin
                            q[0] <= new_e;
                        end
                    end
                    2'b10: begin
                        q[count[0]] <= new_e;
                        count       <= count + 2'd1;
                    end
                    2'b01: begin
                        q[0]  <= q[1];
                        count <= count - 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Issue gating must keep a push from ever landing on a full queue.
    assert property (@(posedge clk) disable iff (!rst) (push && !pop) |-> (count != 2'd2));
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch-side initiator for the word-indexed instruction memory. That memory has 1-cycle synchronous read latency: the word at read_address appears on instruction the next cycle.
- Holds the fetch PC, issues one read per cycle, and buffers returned words in a 2-entry output queue.
- Presents {pc, instruction} to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with flush of queued and in-flight fetches.

Parameters:
- RESET_PC, 32'd0, word index fetched first after reset release.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- mem_read_address  out  32  word index driven to instruction memory read_address.
- mem_instruction  in  32  instruction memory output; valid 1 cycle after the address was presented.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts head this cycle.
- out_instruction  out  32  instruction word at queue head.
- out_pc  out  32  word index the head instruction was fetched from.
- redirect_valid  in  1  redirect fetch stream this cycle.
- redirect_pc  in  32  new word index.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC, inflight=0, inflight_pc=0, queue count=0.
  - out_valid=0, out_instruction=0, out_pc=0, mem_read_address=RESET_PC.
- Definitions:
  - pop = out_valid & out_ready.
  - occ = count + inflight - pop.
  - issue = (occ < 2) | redirect_valid.
- mem_read_address (combinational):
  - redirect_valid ? redirect_pc : fetch_pc.
  - The memory reads every cycle; only issued reads are tracked.
- On issue (posedge):
  - inflight <= 1; inflight_pc <= mem_read_address.
  - fetch_pc <= mem_read_address + 1, mod 2^32 (0xFFFFFFFF wraps to 0).
- No issue: inflight <= 0; fetch_pc holds.
- Response: when inflight=1, mem_instruction is written with tag inflight_pc into the queue tail. This happens the same edge a new issue is registered.
- Queue:
  - 2-entry FIFO, head registered.
  - Simultaneous push+pop is allowed at any count.
  - Issue gating guarantees a push never finds the queue full. Push at full is an assertion failure.
- Redirect (highest priority):
  - Queue count <= 0 and the current inflight response is discarded, not written.
  - redirect_pc is issued this cycle: inflight <= 1, inflight_pc <= redirect_pc, fetch_pc <= redirect_pc+1.
  - The out_valid/out_ready handshake in a redirect cycle is void (pop ignored).
  - out_valid = (count != 0) & ~redirect_valid.
  - Latency: redirect at cycle N → out_valid with out_pc=redirect_pc at N+2.
  - Back-to-back redirects: each one supersedes the previous; only the last target is returned.
- Throughput:
  - With out_ready held 1: one instruction per cycle, sequential PCs, after 2-cycle startup from reset release. First out_valid occurs 2 edges after the first sampled rst=1.
- Stall behaviour:
  - out_ready=0 fills the queue to 2 entries and then stops issuing.
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - After out_ready returns to 1, the next PC is presented without loss or duplication.
- Mid-operation reset: async clear of all state; restart from RESET_PC after release.
- mem_instruction is ignored whenever inflight=0, including the memory's own reset-zero output.

Test Plan:
- Reset release, memory word[i]=0x1000+i, out_ready=1 → out_valid rises 2 cycles later; out_pc 0,1,2,3… consecutive cycles; out_instruction 0x1000,0x1001,…
- Stall: out_ready=0 for 5 cycles at out_pc=3 → out_pc=3 / 0x1003 stable, issue stops after queue holds pc 3,4; on release, sequence 3,4,5,6 with no gaps or repeats.
- redirect_valid pulse, redirect_pc=20, while queue holds 2 entries → queue flushed; out_valid=0 next cycle; out_pc=20 two cycles after redirect; then 21, 22.
- Redirect to 5 then 9 on consecutive cycles → first valid out_pc=9; no instruction from pc 5 is ever presented.
- RESET_PC=0xFFFFFFFE → out_pc 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- rst=0 asserted mid-stream (async, between edges) → out_valid=0, mem_read_address=RESET_PC immediately; after release, stream restarts at RESET_PC.
